// File: rtl/ram_file.sv
// Banked PIC16F register file: decodes {bank, offset} into SFR, banked GPR and common space.
// Define RAM_FILE_CLEAR_EN to build the power-on clear sequencer that zeroes all GPRs after reset.
module ram_file (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] ram_file_address,
  input  logic       rd_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       sfr_hit,
  output logic       busy
);
  localparam int DEPTH = 336;

  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_rd_data;
  logic       r_rd_valid;
  logic       r_sfr_hit;

  logic [1:0] w_bank;
  logic [6:0] w_off;
  logic       w_sfr;
  logic       w_common;
  logic [8:0] w_idx;
  logic       w_busy;
  logic       w_clr_we;
  logic [8:0] w_clr_idx;
  logic       w_mem_we;
  logic [8:0] w_mem_idx;
  logic [7:0] w_mem_wdata;

  assign w_bank   = ram_file_address[8:7];
  assign w_off    = ram_file_address[6:0];
  assign w_sfr    = (w_off[6:5] == 2'b00);
  assign w_common = (w_off[6:4] == 3'b111);

  // bank*80 is built as bank*64 + bank*16 to avoid a multiplier
  always_comb begin
    w_idx = 9'd0;
    if (w_common)
      w_idx = 9'd320 + {5'd0, w_off[3:0]};
    else if (!w_sfr)
      w_idx = {1'b0, w_bank, 6'd0} + {3'b000, w_bank, 4'd0} + {2'b00, w_off} - 9'd32;
  end

`ifdef RAM_FILE_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t     r_state;
  logic [8:0] r_clr_idx;
  logic       r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= 9'd0;
      r_busy    <= 1'b1;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_idx == 9'(DEPTH - 1)) begin
        r_state   <= ST_READY;
        r_clr_idx <= 9'd0;
        r_busy    <= 1'b0;
      end else begin
        r_clr_idx <= r_clr_idx + 9'd1;
      end
    end
  end

  // gated by rst_n so storage is left alone while reset is held
  assign w_busy    = r_busy;
  assign w_clr_we  = (r_state == ST_CLEAR) && rst_n;
  assign w_clr_idx = r_clr_idx;
`else
  assign w_busy    = 1'b0;
  assign w_clr_we  = 1'b0;
  assign w_clr_idx = 9'd0;
`endif

  assign w_mem_we    = w_clr_we || (wr_en && !w_busy && !w_sfr);
  assign w_mem_idx   = w_clr_we ? w_clr_idx : w_idx;
  assign w_mem_wdata = w_clr_we ? 8'h00 : wr_data;

  always_ff @(posedge clk) begin
    if (w_mem_we)
      r_mem[w_mem_idx] <= w_mem_wdata;
  end

  // read samples the pre-write byte, giving read-before-write on a shared index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_sfr_hit  <= 1'b0;
    end else begin
      r_rd_valid <= rd_en && !w_busy;
      if (rd_en && !w_busy) begin
        r_rd_data <= w_sfr ? 8'h00 : r_mem[w_idx];
        r_sfr_hit <= w_sfr;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign sfr_hit  = r_sfr_hit;
  assign busy     = w_busy;
endmodule

// File: tb/tb_ram_file.sv
// Scoreboard bench for ram_file: reads push expected bytes, a negedge monitor pops on rd_valid.
module tb_ram_file;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] addr;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] wdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       sfr_hit;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int tag   = 0;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] d;
    logic       s;
  } exp_t;
  exp_t exp_q[$];

`ifdef RAM_FILE_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  ram_file dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ram_file_address (addr),
    .rd_en            (rd_en),
    .wr_en            (wr_en),
    .wr_data          (wdata),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .sfr_hit          (sfr_hit),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr_en = 1'b1; rd_en = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, input logic [7:0] d, input logic s);
    exp_t e;
    e.tag = 8'(tag); e.d = d; e.s = s;
    tag++;
    exp_q.push_back(e);
    addr = a; rd_en = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rd_valid: got data %02h, expected no read", rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e.d || sfr_hit !== e.s) begin
          n_err++;
          $display("FAIL read_%0d: got data %02h sfr %0b, expected data %02h sfr %0b",
                   e.tag, rd_data, sfr_hit, e.d, e.s);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    rd_en = CLR;
    wr_en = 1'b0;
    addr  = 9'h020;
    wdata = 8'h00;
    #12;
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_sfr_hit", sfr_hit, 1'b0);
    chk("reset_busy", busy, CLR);
    #10 rst_n = 1'b1;

`ifdef RAM_FILE_CLEAR_EN
    cnt = 0;
    for (int i = 1; i <= 336; i++) begin
      @(posedge clk); #1;
      if (i < 336 && busy === 1'b1 && rd_valid === 1'b0) cnt++;
    end
    chk("clear_busy_cycles", cnt, 335);
    chk("busy_after_clear", busy, 1'b0);
    rd(9'h020, 8'h00, 1'b0);
    rd(9'h1EF, 8'h00, 1'b0);
    rd(9'h07F, 8'h00, 1'b0);
`else
    chk("busy_default", busy, 1'b0);
`endif

    // common area mirror
    wr(9'h075, 8'h5A);
    rd(9'h0F5, 8'h5A, 1'b0);
    rd(9'h175, 8'h5A, 1'b0);
    rd(9'h1F5, 8'h5A, 1'b0);
    rd(9'h075, 8'h5A, 1'b0);

    // banks distinct, last banked GPR vs first common byte
    wr(9'h020, 8'h11);
    wr(9'h0A0, 8'h22);
    wr(9'h1EF, 8'h77);
    wr(9'h170, 8'h88);
    rd(9'h020, 8'h11, 1'b0);
    rd(9'h0A0, 8'h22, 1'b0);
    @(posedge clk); #1;
    chk("hold_rd_valid", rd_valid, 1'b0);
    chk("hold_rd_data", rd_data, 8'h22);
    rd(9'h1EF, 8'h77, 1'b0);
    rd(9'h0F0, 8'h88, 1'b0);

    // SFR space
    wr(9'h005, 8'h33);
    rd(9'h005, 8'h00, 1'b1);
    rd(9'h01F, 8'h00, 1'b1);
    rd(9'h085, 8'h00, 1'b1);
    rd(9'h020, 8'h11, 1'b0);
    rd(9'h075, 8'h5A, 1'b0);

    // read-modify-write on one index
    wr(9'h030, 8'h40);
    begin
      exp_t e;
      e.tag = 8'(tag); e.d = 8'h40; e.s = 1'b0;
      tag++;
      exp_q.push_back(e);
    end
    addr = 9'h030; wdata = 8'h41; rd_en = 1'b1; wr_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    rd(9'h030, 8'h41, 1'b0);

    // reset during a read result
    addr = 9'h020; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("midread_valid", rd_valid, 1'b1);
    chk("midread_data", rd_data, 8'h11);
    #1 rst_n = 1'b0;
    #1;
    chk("midread_valid_drop", rd_valid, 1'b0);
    chk("midread_data_reset", rd_data, 8'h00);
    chk("midread_busy", busy, CLR);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

`ifdef RAM_FILE_CLEAR_EN
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midclear_busy", busy, 1'b1);
    #2 rst_n = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (busy === 1'b1 && cnt < 400);
    chk("restart_clear_len", cnt, 336);
`else
    chk("busy_after_reset", busy, 1'b0);
`endif

    rd(9'h020, CLR ? 8'h00 : 8'h11, 1'b0);
    rd(9'h075, CLR ? 8'h00 : 8'h5A, 1'b0);
    rd(9'h0A0, CLR ? 8'h00 : 8'h22, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
